req_encoder: RTL and testbench

REQ_ENCODER -- requirements
Module: req_encoder

---
 rtl/req_encoder_pkg.sv | 16 +
 rtl/req_encoder_prio_pick.sv | 33 +++
 rtl/req_encoder.sv | 103 ++++++++++
 tb/tb_req_encoder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/req_encoder_pkg.sv
// rtl/req_encoder_pkg.sv - shared constants and FSM state type for req_encoder
// Contents:
//   N_LINES  number of request lines
//   CODE_W   width of the granted-index code
//   state_e  output-stage FSM state (IDLE: no code offered, HOLD: code offered)
package req_encoder_pkg;

  localparam int N_LINES = 4;
  localparam int CODE_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/req_encoder_prio_pick.sv
// rtl/req_encoder_prio_pick.sv - combinational rotating-start priority picker
// Ports:
//   vec    in   [0:N_LINES-1] candidate bits, bit i stands for index i
//   start  in   [CODE_W-1:0]  index searched first; search wraps N_LINES-1 -> 0
//   found  out  1             at least one bit of vec is set
//   idx    out  [CODE_W-1:0]  first set index at or after start (0 when none)
module prio_pick
  import req_encoder_pkg::*;
(
  input  logic [0:N_LINES-1] vec,
  input  logic [CODE_W-1:0]  start,
  output logic               found,
  output logic [CODE_W-1:0]  idx
);

  logic [CODE_W-1:0] cand;

  // Walk the offsets from farthest to nearest so the last hit written is the
  // one closest to start; the 2-bit add wraps the search around naturally.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = N_LINES - 1; k >= 0; k--) begin
      cand = start + CODE_W'(k);
      if (vec[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/req_encoder.sv
// rtl/req_encoder.sv - request-capturing priority encoder with valid/ready code output
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   enable     in   1      capture req into pending when 1
//   req        in   [0:3]  request lines, bit i requests code i
//   out_ready  in   1      consumer accepts the offered code
//   out_valid  out  1      {a0,a1} holds a valid code
//   a0         out  1      code MSB
//   a1         out  1      code LSB
//   pending    out  [0:3]  pending-request register
//   overrun    out  [0:3]  sticky: request arrived while line already pending
// Parameter ROUND_ROBIN: 0 = fixed priority (line 0 highest), 1 = rotating.
module req_encoder
  import req_encoder_pkg::*;
#(
  parameter int ROUND_ROBIN = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [0:3] req,
  input  logic       out_ready,
  output logic       out_valid,
  output logic       a0,
  output logic       a1,
  output logic [0:3] pending,
  output logic [0:3] overrun
);

  state_e             state_q, state_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [CODE_W-1:0]  last_q, last_d;
  logic [0:N_LINES-1] pending_q, pending_d;
  logic [0:N_LINES-1] overrun_q, overrun_d;

  logic [0:N_LINES-1] capture;
  logic [0:N_LINES-1] clear;
  logic [CODE_W-1:0]  start_idx;
  logic [CODE_W-1:0]  win_idx;
  logic               win_found;
  logic               grant;

  // Fixed priority is the same picker with the search pinned at line 0.
  assign start_idx = (ROUND_ROBIN != 0) ? last_q + CODE_W'(1) : '0;

  prio_pick u_pick (
    .vec   (pending_q),
    .start (start_idx),
    .found (win_found),
    .idx   (win_idx)
  );

  always_comb begin
    capture = enable ? req : '0;
    // The winner is chosen from pending as it stood before this edge, so a
    // request captured now is issued at the earliest on the following edge.
    grant = win_found && ((state_q == IDLE) || out_ready);

    clear = '0;
    for (int i = 0; i < N_LINES; i++) begin
      clear[i] = grant && (win_idx == CODE_W'(i));
    end

    // Capture is ORed in after the clear so a same-edge re-request survives.
    pending_d = (pending_q & ~clear) | capture;
    overrun_d = overrun_q | (capture & pending_q & ~clear);

    state_d = state_q;
    code_d  = code_q;
    last_d  = last_q;
    if (grant) begin
      state_d = HOLD;
      code_d  = win_idx;
      last_d  = win_idx;
    end else if ((state_q == HOLD) && out_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      code_q    <= '0;
      last_q    <= CODE_W'(N_LINES - 1);
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      last_q    <= last_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign a0        = code_q[1];
  assign a1        = code_q[0];
  assign pending   = pending_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_req_encoder.sv
// tb/tb_req_encoder.sv - self-checking bench for req_encoder, fixed and rotating modes
module tb_req_encoder;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [0:3] req;
  logic       out_ready;

  logic       fp_valid, fp_a0, fp_a1;
  logic [0:3] fp_pend, fp_ovr;
  logic       rr_valid, rr_a0, rr_a1;
  logic [0:3] rr_pend, rr_ovr;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 0;

  req_encoder #(.ROUND_ROBIN(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .out_ready(out_ready),
    .out_valid(fp_valid), .a0(fp_a0), .a1(fp_a1), .pending(fp_pend), .overrun(fp_ovr)
  );

  req_encoder #(.ROUND_ROBIN(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .out_ready(out_ready),
    .out_valid(rr_valid), .a0(rr_a0), .a1(rr_a1), .pending(rr_pend), .overrun(rr_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: index 0 = fixed priority, index 1 = rotating priority.
  bit         m_valid [2];
  int         m_code  [2];
  int         m_last  [2];
  logic [0:3] m_pend  [2];
  logic [0:3] m_ovr   [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_valid[k] = 0; m_code[k] = 0; m_last[k] = 3; m_pend[k] = '0; m_ovr[k] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit may_issue;
        int w;
        int s;
        may_issue = !m_valid[k] || out_ready;
        w = -1;
        s = (k == 1) ? (m_last[k] + 1) % 4 : 0;
        if (may_issue) begin
          for (int j = 0; j < 4; j++) begin
            if (w < 0 && m_pend[k][(s + j) % 4]) w = (s + j) % 4;
          end
        end
        for (int i = 0; i < 4; i++) begin
          if (enable && req[i] && m_pend[k][i] && i != w) m_ovr[k][i] = 1'b1;
        end
        if (w >= 0) begin
          m_pend[k][w] = 1'b0;
          m_code[k]    = w;
          m_last[k]    = w;
          m_valid[k]   = 1;
        end else if (may_issue) begin
          m_valid[k] = 0;
        end
        for (int i = 0; i < 4; i++) begin
          if (enable && req[i]) m_pend[k][i] = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Continuous comparison against the model at every falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("fp_valid", {31'd0, fp_valid}, {31'd0, m_valid[0]});
      chk("fp_pending", {28'd0, fp_pend}, {28'd0, m_pend[0]});
      chk("fp_overrun", {28'd0, fp_ovr}, {28'd0, m_ovr[0]});
      if (m_valid[0]) chk("fp_code", {30'd0, fp_a0, fp_a1}, m_code[0]);
      chk("rr_valid", {31'd0, rr_valid}, {31'd0, m_valid[1]});
      chk("rr_pending", {28'd0, rr_pend}, {28'd0, m_pend[1]});
      chk("rr_overrun", {28'd0, rr_ovr}, {28'd0, m_ovr[1]});
      if (m_valid[1]) chk("rr_code", {30'd0, rr_a0, rr_a1}, m_code[1]);
    end
  end

  // Drive inputs shortly after a falling edge, then advance to the next one.
  task automatic cyc(input logic en, input logic [0:3] r, input logic rdy);
    #2;
    rst_n = 1'b1; enable = en; req = r; out_ready = rdy;
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0; enable = 1'b0; req = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic chk_both(input string name, input logic v, input logic [1:0] code,
                          input logic [0:3] p, input logic [0:3] o);
    chk({name, "_fp_valid"}, {31'd0, fp_valid}, {31'd0, v});
    chk({name, "_rr_valid"}, {31'd0, rr_valid}, {31'd0, v});
    if (v) begin
      chk({name, "_fp_code"}, {30'd0, fp_a0, fp_a1}, {30'd0, code});
      chk({name, "_rr_code"}, {30'd0, rr_a0, rr_a1}, {30'd0, code});
    end
    chk({name, "_fp_pend"}, {28'd0, fp_pend}, {28'd0, p});
    chk({name, "_rr_pend"}, {28'd0, rr_pend}, {28'd0, p});
    chk({name, "_fp_ovr"}, {28'd0, fp_ovr}, {28'd0, o});
    chk({name, "_rr_ovr"}, {28'd0, rr_ovr}, {28'd0, o});
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; req = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_both("reset", 1'b0, 2'b00, 4'b0000, 4'b0000);
    cmp_en = 1;

    // Two requests in one cycle drain back-to-back, lowest line first.
    cyc(1, 4'b0110, 1); chk_both("r030_cap", 1'b0, 2'b00, 4'b0110, 4'b0000);
    cyc(1, 4'b0000, 1); chk_both("r030_c1", 1'b1, 2'b01, 4'b0010, 4'b0000);
    cyc(1, 4'b0000, 1); chk_both("r030_c2", 1'b1, 2'b10, 4'b0000, 4'b0000);
    cyc(1, 4'b0000, 1); chk_both("r030_idle", 1'b0, 2'b00, 4'b0000, 4'b0000);

    // All lines held: rotating mode cycles, fixed mode sticks at line 0.
    do_reset();
    cyc(1, 4'b1111, 1);
    for (int j = 0; j < 5; j++) begin
      cyc(1, 4'b1111, 1);
      chk("r031_fp_valid", {31'd0, fp_valid}, 32'd1);
      chk("r031_fp_code", {30'd0, fp_a0, fp_a1}, 32'd0);
      chk("r031_rr_valid", {31'd0, rr_valid}, 32'd1);
      chk("r031_rr_code", {30'd0, rr_a0, rr_a1}, j % 4);
    end

    // Stalled consumer: code stays put, then one accept returns to idle.
    do_reset();
    cyc(1, 4'b0001, 0);
    for (int j = 0; j < 5; j++) begin
      cyc(1, 4'b0000, 0);
      chk_both("r032_hold", 1'b1, 2'b11, 4'b0000, 4'b0000);
    end
    cyc(1, 4'b0000, 1); chk_both("r032_idle", 1'b0, 2'b00, 4'b0000, 4'b0000);

    // Capture gated by enable.
    do_reset();
    cyc(0, 4'b1000, 1); chk_both("r033_off1", 1'b0, 2'b00, 4'b0000, 4'b0000);
    cyc(0, 4'b1000, 1); chk_both("r033_off2", 1'b0, 2'b00, 4'b0000, 4'b0000);
    cyc(1, 4'b1000, 1); chk_both("r033_on", 1'b0, 2'b00, 4'b1000, 4'b0000);
    cyc(1, 4'b0000, 1); chk_both("r033_code", 1'b1, 2'b00, 4'b0000, 4'b0000);

    // Repeated request on a pending line sets a sticky overrun.
    do_reset();
    cyc(1, 4'b1000, 0);
    cyc(1, 4'b0010, 0); chk_both("r034_fresh", 1'b1, 2'b00, 4'b0010, 4'b0000);
    cyc(1, 4'b0010, 0);
    cyc(1, 4'b0010, 0); chk_both("r034_ovr", 1'b1, 2'b00, 4'b0010, 4'b0010);
    cyc(1, 4'b0000, 1);
    cyc(1, 4'b0000, 1);
    cyc(1, 4'b0000, 1); chk_both("r034_sticky", 1'b0, 2'b00, 4'b0000, 4'b0010);
    do_reset();
    chk_both("r034_clr", 1'b0, 2'b00, 4'b0000, 4'b0000);

    // Asynchronous reset between edges while a code is held.
    cyc(1, 4'b1100, 0);
    cyc(1, 4'b1100, 0);
    cyc(1, 4'b0000, 0); chk_both("r035_hold", 1'b1, 2'b00, 4'b1100, 4'b0100);
    #2 rst_n = 1'b0;
    #1 chk_both("r035_async", 1'b0, 2'b00, 4'b0000, 4'b0000);
    chk("r035_fp_a", {30'd0, fp_a0, fp_a1}, 32'd0);
    chk("r035_rr_a", {30'd0, rr_a0, rr_a1}, 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      cyc(1, 4'b0000, 1);
      chk_both("r035_after", 1'b0, 2'b00, 4'b0000, 4'b0000);
    end

    // Randomized traffic, model-checked every cycle.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        logic [3:0] r;
        r = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
        cyc($urandom_range(0, 3) != 0, r, $urandom_range(0, 2) != 0);
      end
    end

    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
